// File: rtl/conv_tile_scheduler_pkg.sv
// Shared definitions for the convolution tile scheduler: FSM state type,
// default drain length, counter widths and the saturating-increment helper.
package conv_tile_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } sched_state_e;

  localparam int DRAIN_CYC_DEF = 16;
  localparam int DRAIN_CNT_W   = 10;
  localparam int PERF_W        = 32;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sched_cycle_cnt.sv
// Loadable down-counter with zero flag; times the systolic drain phase.
module sched_cycle_cnt
  import conv_tile_scheduler_pkg::*;
#(
  parameter int WIDTH = DRAIN_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_sync_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Load takes priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load_i) begin
      count_r <= load_val_i;
    end else if (dec_i && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero_o = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/conv_tile_scheduler.sv
// Per-layer tile sequencer: load weights, stream patches, drain, write back.
// Optional cycle counters are compiled in with CONV_SCHED_PERF_EN.
module conv_tile_scheduler
  import conv_tile_scheduler_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_sync_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$clog2(NUM_TILES):0]   tile_idx_o,
  output logic                         wt_load_req_o,
  input  logic                         wt_load_done_i,
  input  logic                         sa_ready_i,
  output logic                         img_start_o,
  input  logic                         img_last_i,
  output logic                         wb_req_o,
  input  logic                         wb_done_i
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]            perf_busy_cyc_o,
  output logic [PERF_W-1:0]            perf_stall_cyc_o
`endif
);

  localparam int TW = $clog2(NUM_TILES) + 1;
  localparam logic [TW-1:0]          LAST_TILE  = TW'(NUM_TILES - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYC - 1);

  sched_state_e  state_r;
  sched_state_e  state_nxt_s;
  logic [TW-1:0] tile_r;
  logic          issued_r;
  logic          start_acc_s;
  logic          pulse_s;
  logic          cnt_load_s;
  logic          cnt_dec_s;
  logic          cnt_zero_s;

  assign start_acc_s = (state_r == IDLE) && start_i;
  assign pulse_s     = (state_r == STREAM) && !issued_r && sa_ready_i;
  assign cnt_load_s  = (state_r == STREAM) && (state_nxt_s == DRAIN);
  assign cnt_dec_s   = (state_r == DRAIN);

  sched_cycle_cnt #(.WIDTH(DRAIN_CNT_W)) u_drain_cnt (
    .clk_i      (clk_i),
    .rst_sync_i (rst_sync_i),
    .load_i     (cnt_load_s),
    .load_val_i (DRAIN_LOAD),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; each state only looks at the handshake it owns.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start_i)                  state_nxt_s = LOAD_W; else state_nxt_s = IDLE;
      LOAD_W:  if (wt_load_done_i)           state_nxt_s = STREAM; else state_nxt_s = LOAD_W;
      STREAM:  if (issued_r && img_last_i)   state_nxt_s = DRAIN;  else state_nxt_s = STREAM;
      DRAIN:   if (cnt_zero_s)               state_nxt_s = WB;     else state_nxt_s = DRAIN;
      WB: begin
        if (!wb_done_i)                 state_nxt_s = WB;
        else if (tile_r < LAST_TILE)    state_nxt_s = LOAD_W;
        else                            state_nxt_s = DONE;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Tile index and per-tile issued flag.
  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      tile_r   <= {TW{1'b0}};
      issued_r <= 1'b0;
    end else begin
      if (start_acc_s) begin
        tile_r <= {TW{1'b0}};
      end else if ((state_r == WB) && wb_done_i && (tile_r < LAST_TILE)) begin
        tile_r <= tile_r + TW'(1);
      end else begin
        tile_r <= tile_r;
      end
      if (pulse_s) begin
        issued_r <= 1'b1;
      end else if (state_r != STREAM) begin
        issued_r <= 1'b0;
      end else begin
        issued_r <= issued_r;
      end
    end
  end

  // Output decode; everything is held low while reset is applied.
  always_comb begin
    busy_o        = 1'b0;
    done_o        = 1'b0;
    wt_load_req_o = 1'b0;
    img_start_o   = 1'b0;
    wb_req_o      = 1'b0;
    tile_idx_o    = {TW{1'b0}};
    if (rst_sync_i) begin
      tile_idx_o = {TW{1'b0}};
    end else begin
      busy_o        = (state_r != IDLE);
      done_o        = (state_r == DONE);
      wt_load_req_o = (state_r == LOAD_W);
      img_start_o   = pulse_s;
      wb_req_o      = (state_r == WB);
      tile_idx_o    = tile_r;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_busy_r;
  logic [PERF_W-1:0] perf_stall_r;

  // Busy and pre-issue stall cycle counters, cleared by each accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_sync_i || start_acc_s) begin
      perf_busy_r  <= {PERF_W{1'b0}};
      perf_stall_r <= {PERF_W{1'b0}};
    end else begin
      if (state_r != IDLE) begin
        perf_busy_r <= sat_inc(perf_busy_r);
      end else begin
        perf_busy_r <= perf_busy_r;
      end
      if ((state_r == STREAM) && !issued_r && !sa_ready_i) begin
        perf_stall_r <= sat_inc(perf_stall_r);
      end else begin
        perf_stall_r <= perf_stall_r;
      end
    end
  end

  assign perf_busy_cyc_o  = rst_sync_i ? {PERF_W{1'b0}} : perf_busy_r;
  assign perf_stall_cyc_o = rst_sync_i ? {PERF_W{1'b0}} : perf_stall_r;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench: a 2-tile/4-drain instance and a 1-tile/1-drain instance.
module tb_conv_tile_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, wld_a, sar_a, last_a, wbd_a;
  logic       busy_a, done_a, wt_a, img_a, wb_a;
  logic [1:0] tile_a;
  logic       start_b, wld_b, sar_b, last_b, wbd_b;
  logic       busy_b, done_b, wt_b, img_b, wb_b;
  logic [0:0] tile_b;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] pbusy_a, pstall_a, pbusy_b, pstall_b;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   img_cnt_a, done_cnt_a, done_cnt_b;
  logic cnt_clr;

  conv_tile_scheduler #(.NUM_TILES(2), .DRAIN_CYC(4)) dut_a (
    .clk_i(clk), .rst_sync_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .tile_idx_o(tile_a), .wt_load_req_o(wt_a), .wt_load_done_i(wld_a), .sa_ready_i(sar_a),
    .img_start_o(img_a), .img_last_i(last_a), .wb_req_o(wb_a), .wb_done_i(wbd_a)
`ifdef CONV_SCHED_PERF_EN
    , .perf_busy_cyc_o(pbusy_a), .perf_stall_cyc_o(pstall_a)
`endif
  );

  conv_tile_scheduler #(.NUM_TILES(1), .DRAIN_CYC(1)) dut_b (
    .clk_i(clk), .rst_sync_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .tile_idx_o(tile_b), .wt_load_req_o(wt_b), .wt_load_done_i(wld_b), .sa_ready_i(sar_b),
    .img_start_o(img_b), .img_last_i(last_b), .wb_req_o(wb_b), .wb_done_i(wbd_b)
`ifdef CONV_SCHED_PERF_EN
    , .perf_busy_cyc_o(pbusy_b), .perf_stall_cyc_o(pstall_b)
`endif
  );

  always @(posedge clk) begin
    if (cnt_clr) begin
      img_cnt_a  <= 0;
      done_cnt_a <= 0;
      done_cnt_b <= 0;
    end else begin
      img_cnt_a  <= img_cnt_a + int'(img_a);
      done_cnt_a <= done_cnt_a + int'(done_a);
      done_cnt_b <= done_cnt_b + int'(done_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flag order: busy, wt_load_req, img_start, wb_req, done.
  task automatic chk_a(input string tag, input logic [4:0] flags, input int tile);
    check({tag, ".a.flags"}, 32'({busy_a, wt_a, img_a, wb_a, done_a}), 32'(flags));
    check({tag, ".a.tile"}, 32'(tile_a), tile);
  endtask

  task automatic chk_b(input string tag, input logic [4:0] flags, input int tile);
    check({tag, ".b.flags"}, 32'({busy_b, wt_b, img_b, wb_b, done_b}), 32'(flags));
    check({tag, ".b.tile"}, 32'(tile_b), tile);
  endtask

  task automatic start_layer_a(input int prev_tile);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    start_a = 1'b1;
    #1 chk_a("start", 5'b00000, prev_tile);
    @(negedge clk);
  endtask

  // Runs one tile on dut_a starting in its first LOAD_W cycle.
  task automatic a_tile(input int tile, input int stall, input bit early_last,
                        input bit last_tile, input bit abort);
    // Handshakes that LOAD_W does not consume must be ignored.
    start_a = 1'b0; wld_a = 1'b0; wbd_a = 1'b1; last_a = 1'b1; sar_a = 1'b1;
    #1 chk_a("ldw1", 5'b11000, tile);
    @(negedge clk);
    wld_a = 1'b1;
    #1 chk_a("ldw2", 5'b11000, tile);
    @(negedge clk);
    wld_a = 1'b0; wbd_a = 1'b0; last_a = 1'b0; start_a = 1'b1;
    for (int i = 0; i < stall; i++) begin
      sar_a  = 1'b0;
      last_a = early_last && (i == 1);
      #1 chk_a("stall", 5'b10000, tile);
      @(negedge clk);
      start_a = 1'b0;
    end
    sar_a = 1'b1; last_a = 1'b0;
    #1 chk_a("pulse", 5'b10100, tile);
    @(negedge clk);
    start_a = 1'b0; last_a = 1'b1;
    #1 chk_a("post", 5'b10000, tile);
    @(negedge clk);
    last_a = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (abort && (d == 1)) begin
        rst = 1'b1;
        #1 chk_a("inrst", 5'b00000, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_a("aftrst", 5'b00000, 0);
        return;
      end
      #1 chk_a("drain", 5'b10000, tile);
      @(negedge clk);
    end
    #1 chk_a("wb1", 5'b10010, tile);
    @(negedge clk);
    wbd_a = 1'b1;
    #1 chk_a("wb2", 5'b10010, tile);
    @(negedge clk);
    wbd_a = 1'b0;
    if (last_tile) begin
      #1 chk_a("done", 5'b10001, tile);
      @(negedge clk);
      #1 chk_a("idle", 5'b00000, tile);
    end
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b1;
    start_a = 1'b0; wld_a = 1'b0; sar_a = 1'b0; last_a = 1'b0; wbd_a = 1'b0;
    start_b = 1'b0; wld_b = 1'b0; sar_b = 1'b0; last_b = 1'b0; wbd_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk_a("reset", 5'b00000, 0);
    chk_b("reset", 5'b00000, 0);
    rst = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    #1 chk_a("idle0", 5'b00000, 0);

    // Layer 1: all handshakes answered after one cycle.
    start_layer_a(0);
    a_tile(0, 0, 1'b0, 1'b0, 1'b0);
    a_tile(1, 0, 1'b0, 1'b1, 1'b0);
    check("l1.img_pulses", 32'(img_cnt_a), 32'd2);
    check("l1.done_pulses", 32'(done_cnt_a), 32'd1);
`ifdef CONV_SCHED_PERF_EN
    check("l1.perf_busy", pbusy_a, 32'd21);
    check("l1.perf_stall", pstall_a, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    #1 chk_a("hold", 5'b00000, 1);

    // Layer 2: 7-cycle stall with an early img_last on the first tile.
    start_layer_a(1);
    a_tile(0, 7, 1'b1, 1'b0, 1'b0);
    a_tile(1, 0, 1'b0, 1'b1, 1'b0);
    check("l2.img_pulses", 32'(img_cnt_a), 32'd2);
    check("l2.done_pulses", 32'(done_cnt_a), 32'd1);
`ifdef CONV_SCHED_PERF_EN
    check("l2.perf_stall", pstall_a, 32'd7);
    check("l2.perf_busy", pbusy_a, 32'd28);
`endif

    // Layer 3: reset during the second tile's drain, then a full layer.
    start_layer_a(1);
    a_tile(0, 0, 1'b0, 1'b0, 1'b0);
    a_tile(1, 0, 1'b0, 1'b0, 1'b1);
    check("l3.done_pulses", 32'(done_cnt_a), 32'd0);
    sar_a = 1'b0;
    start_layer_a(0);
    a_tile(0, 0, 1'b0, 1'b0, 1'b0);
    a_tile(1, 0, 1'b0, 1'b1, 1'b0);
    check("l4.img_pulses", 32'(img_cnt_a), 32'd2);
    check("l4.done_pulses", 32'(done_cnt_a), 32'd1);

    // Single tile, single drain cycle on dut_b.
    start_b = 1'b1;
    #1 chk_b("start", 5'b00000, 0);
    @(negedge clk);
    start_b = 1'b0; wld_b = 1'b1;
    #1 chk_b("ldw", 5'b11000, 0);
    @(negedge clk);
    wld_b = 1'b0; sar_b = 1'b1;
    #1 chk_b("pulse", 5'b10100, 0);
    @(negedge clk);
    last_b = 1'b1;
    #1 chk_b("post", 5'b10000, 0);
    @(negedge clk);
    last_b = 1'b0; sar_b = 1'b0;
    #1 chk_b("drain", 5'b10000, 0);
    @(negedge clk);
    wbd_b = 1'b1;
    #1 chk_b("wb", 5'b10010, 0);
    @(negedge clk);
    wbd_b = 1'b0;
    #1 chk_b("done", 5'b10001, 0);
    @(negedge clk);
    #1 chk_b("idle", 5'b00000, 0);
    check("b.done_pulses", 32'(done_cnt_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
